// File: rtl/seq_alu.sv
// Sequential ALU: one-cycle logic/arith ops plus iterative Booth multiply and
// restoring divide, with a start/ready/done handshake and a registered {HI,LO} result.
module seq_alu #(
    parameter int BITS      = 32,
    parameter int SIG_COUNT = 13,
    parameter int PC_STEP   = 4
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 start,
    input  logic [SIG_COUNT-1:0] ctrl_signal,
    input  logic [BITS-1:0]      X,
    input  logic [BITS-1:0]      Y,
    output logic                 ready,
    output logic                 done,
    output logic [2*BITS-1:0]    result,
    output logic                 zero,
    output logic                 neg,
    output logic                 err_op,
    output logic                 err_div0
);

    localparam int SW = $clog2(BITS);
    localparam logic [SW:0] BITS_W = (SW+1)'(BITS);

    localparam int OP_ADD = 0;
    localparam int OP_SUB = 1;
    localparam int OP_MUL = 2;
    localparam int OP_DIV = 3;
    localparam int OP_SHR = 4;
    localparam int OP_SHL = 5;
    localparam int OP_ROR = 6;
    localparam int OP_ROL = 7;
    localparam int OP_AND = 8;
    localparam int OP_OR  = 9;
    localparam int OP_NEG = 10;
    localparam int OP_NOT = 11;
    localparam int OP_INC = 12;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     cnt_q, cnt_d;
    logic [BITS:0]     acc_q, acc_d;     // Booth A / division remainder
    logic [BITS-1:0]   mq_q, mq_d;       // Booth multiplier / dividend->quotient
    logic [BITS-1:0]   m_q, m_d;         // multiplicand / divisor magnitude
    logic              qm1_q, qm1_d;
    logic              sx_q, sx_d;
    logic              sq_q, sq_d;
    logic [2*BITS-1:0] result_q, result_d;
    logic              zero_q, zero_d;
    logic              neg_q, neg_d;
    logic              err_op_q, err_op_d;
    logic              err_div0_q, err_div0_d;

    logic [SW-1:0]     sh;
    logic [BITS-1:0]   lo;
    logic              op_valid;

    always_comb begin
        sh       = Y[SW-1:0];
        op_valid = (ctrl_signal != '0) &&
                   ((ctrl_signal & (ctrl_signal - 1'b1)) == '0);
        lo       = '0;
        case (1'b1)
            ctrl_signal[OP_ADD]: lo = X + Y;
            ctrl_signal[OP_SUB]: lo = X - Y;
            ctrl_signal[OP_SHR]: lo = X >> sh;
            ctrl_signal[OP_SHL]: lo = X << sh;
            ctrl_signal[OP_ROR]: lo = (X >> sh) | (X << (BITS_W - {1'b0, sh}));
            ctrl_signal[OP_ROL]: lo = (X << sh) | (X >> (BITS_W - {1'b0, sh}));
            ctrl_signal[OP_AND]: lo = X & Y;
            ctrl_signal[OP_OR]:  lo = X | Y;
            ctrl_signal[OP_NEG]: lo = '0 - Y;
            ctrl_signal[OP_NOT]: lo = ~Y;
            ctrl_signal[OP_INC]: lo = Y + BITS'(PC_STEP);
            default:             lo = '0;
        endcase
    end

    logic [BITS:0]     sum;
    logic [BITS:0]     shifted;
    logic [BITS:0]     trial;
    logic [BITS-1:0]   q_fix;
    logic [BITS-1:0]   r_fix;
    logic [2*BITS-1:0] res_n;
    logic              load;
    logic              eop_n;
    logic              ediv_n;
    logic              last;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mq_d       = mq_q;
        m_d        = m_q;
        qm1_d      = qm1_q;
        sx_d       = sx_q;
        sq_d       = sq_q;
        result_d   = result_q;
        zero_d     = zero_q;
        neg_d      = neg_q;
        err_op_d   = err_op_q;
        err_div0_d = err_div0_q;
        sum        = '0;
        shifted    = '0;
        trial      = '0;
        q_fix      = '0;
        r_fix      = '0;
        res_n      = '0;
        load       = 1'b0;
        eop_n      = 1'b0;
        ediv_n     = 1'b0;
        last       = (cnt_q == SW'(BITS-1));

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d = '0;
                    if (!op_valid) begin
                        eop_n   = 1'b1;
                        load    = 1'b1;
                        state_d = S_DONE;
                    end else if (ctrl_signal[OP_MUL]) begin
                        acc_d   = '0;
                        mq_d    = Y;
                        m_d     = X;
                        qm1_d   = 1'b0;
                        state_d = S_MUL;
                    end else if (ctrl_signal[OP_DIV]) begin
                        if (Y == '0) begin
                            res_n   = {X, {BITS{1'b0}}};
                            ediv_n  = 1'b1;
                            load    = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            acc_d   = '0;
                            mq_d    = X[BITS-1] ? '0 - X : X;
                            m_d     = Y[BITS-1] ? '0 - Y : Y;
                            sx_d    = X[BITS-1];
                            sq_d    = X[BITS-1] ^ Y[BITS-1];
                            state_d = S_DIV;
                        end
                    end else begin
                        res_n   = {{BITS{lo[BITS-1]}}, lo};
                        load    = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end

            S_MUL: begin
                // A is one bit wider than X so that subtracting the most
                // negative multiplicand cannot overflow.
                case ({mq_q[0], qm1_q})
                    2'b01:   sum = acc_q + {m_q[BITS-1], m_q};
                    2'b10:   sum = acc_q - {m_q[BITS-1], m_q};
                    default: sum = acc_q;
                endcase
                acc_d = {sum[BITS], sum[BITS:1]};
                mq_d  = {sum[0], mq_q[BITS-1:1]};
                qm1_d = mq_q[0];
                if (last) begin
                    res_n   = {acc_d[BITS-1:0], mq_d};
                    load    = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + SW'(1);
                end
            end

            S_DIV: begin
                shifted = {acc_q[BITS-1:0], mq_q[BITS-1]};
                trial   = shifted - {1'b0, m_q};
                acc_d   = trial[BITS] ? shifted : trial;
                mq_d    = {mq_q[BITS-2:0], ~trial[BITS]};
                if (last) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q + SW'(1);
                end
            end

            S_FIX: begin
                // Truncating division: quotient sign from operand signs,
                // remainder sign from the dividend.
                q_fix   = sq_q ? '0 - mq_q : mq_q;
                r_fix   = sx_q ? '0 - acc_q[BITS-1:0] : acc_q[BITS-1:0];
                res_n   = {r_fix, q_fix};
                load    = 1'b1;
                state_d = S_DONE;
            end

            S_DONE: state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase

        if (load) begin
            result_d   = res_n;
            zero_d     = (res_n == '0);
            neg_d      = res_n[2*BITS-1];
            err_op_d   = eop_n;
            err_div0_d = ediv_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            mq_q       <= '0;
            m_q        <= '0;
            qm1_q      <= 1'b0;
            sx_q       <= 1'b0;
            sq_q       <= 1'b0;
            result_q   <= '0;
            zero_q     <= 1'b1;
            neg_q      <= 1'b0;
            err_op_q   <= 1'b0;
            err_div0_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            mq_q       <= mq_d;
            m_q        <= m_d;
            qm1_q      <= qm1_d;
            sx_q       <= sx_d;
            sq_q       <= sq_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            neg_q      <= neg_d;
            err_op_q   <= err_op_d;
            err_div0_q <= err_div0_d;
        end
    end

    assign ready    = (state_q == S_IDLE);
    assign done     = (state_q == S_DONE);
    assign result   = result_q;
    assign zero     = zero_q;
    assign neg      = neg_q;
    assign err_op   = err_op_q;
    assign err_div0 = err_div0_q;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: arithmetic reference model checked every cycle, plus
// directed ops with hand-computed latency/result literals.
module tb_seq_alu;

    localparam int BITS = 32;

    localparam logic [12:0] C_ADD = 13'h0001;
    localparam logic [12:0] C_SUB = 13'h0002;
    localparam logic [12:0] C_MUL = 13'h0004;
    localparam logic [12:0] C_DIV = 13'h0008;
    localparam logic [12:0] C_SHR = 13'h0010;
    localparam logic [12:0] C_SHL = 13'h0020;
    localparam logic [12:0] C_ROR = 13'h0040;
    localparam logic [12:0] C_ROL = 13'h0080;
    localparam logic [12:0] C_AND = 13'h0100;
    localparam logic [12:0] C_OR  = 13'h0200;
    localparam logic [12:0] C_NEG = 13'h0400;
    localparam logic [12:0] C_NOT = 13'h0800;
    localparam logic [12:0] C_INC = 13'h1000;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        start = 1'b0;
    logic [12:0] ctrl_signal = '0;
    logic [31:0] X = '0;
    logic [31:0] Y = '0;
    logic        ready, done, zero, neg, err_op, err_div0;
    logic [63:0] result;

    seq_alu #(.BITS(BITS), .SIG_COUNT(13), .PC_STEP(4)) dut (
        .clk(clk), .clr(clr), .start(start), .ctrl_signal(ctrl_signal),
        .X(X), .Y(Y), .ready(ready), .done(done), .result(result),
        .zero(zero), .neg(neg), .err_op(err_op), .err_div0(err_div0)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: what the outputs must be, from the op definitions alone.
    function automatic void model_op(input logic [12:0] c, input logic [31:0] a,
                                     input logic [31:0] b, output logic [63:0] r,
                                     output logic eop, output logic ediv, output int lat);
        int sa, sb, q, rm, s;
        logic [31:0] lo;
        sa = a; sb = b; s = int'(b[4:0]);
        eop = 1'b0; ediv = 1'b0; lat = 1; lo = '0; r = '0;
        if ($countones(c) != 1) begin
            eop = 1'b1;
        end else if (c == C_MUL) begin
            r = 64'(longint'(sa) * longint'(sb));
            lat = BITS + 1;
        end else if (c == C_DIV) begin
            if (b == 32'h0) begin
                r = {a, 32'h0};
                ediv = 1'b1;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                r = {32'h0, 32'h8000_0000};
                lat = BITS + 2;
            end else begin
                q = sa / sb;
                rm = sa % sb;
                r = {32'(rm), 32'(q)};
                lat = BITS + 2;
            end
        end else begin
            case (c)
                C_ADD: lo = a + b;
                C_SUB: lo = a - b;
                C_SHR: lo = a >> s;
                C_SHL: lo = a << s;
                C_ROR: lo = (a >> s) | (a << (32 - s));
                C_ROL: lo = (a << s) | (a >> (32 - s));
                C_AND: lo = a & b;
                C_OR:  lo = a | b;
                C_NEG: lo = 32'(-sb);
                C_NOT: lo = ~b;
                C_INC: lo = b + 32'd4;
                default: lo = '0;
            endcase
            r = {{32{lo[31]}}, lo};
        end
    endfunction

    logic [63:0] e_res = '0;
    logic        e_zero = 1'b1, e_neg = 1'b0, e_eop = 1'b0, e_ediv = 1'b0, e_done = 1'b0;
    logic [63:0] p_res;
    logic        p_eop, p_ediv;
    bit          m_busy = 1'b0;
    int          m_left = 0;
    int          lat;

    always @(posedge clk) begin
        if (!clr) begin
            m_busy = 1'b0; e_done = 1'b0; e_res = '0;
            e_zero = 1'b1; e_neg = 1'b0; e_eop = 1'b0; e_ediv = 1'b0;
        end else if (e_done) begin
            e_done = 1'b0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 1'b0;
                e_done = 1'b1; e_res = p_res; e_zero = (p_res == '0);
                e_neg = p_res[63]; e_eop = p_eop; e_ediv = p_ediv;
            end
        end else if (start) begin
            model_op(ctrl_signal, X, Y, p_res, p_eop, p_ediv, lat);
            if (lat == 1) begin
                e_done = 1'b1; e_res = p_res; e_zero = (p_res == '0);
                e_neg = p_res[63]; e_eop = p_eop; e_ediv = p_ediv;
            end else begin
                m_busy = 1'b1;
                m_left = lat - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("ready", ready, !m_busy && !e_done);
            chk("done", done, e_done);
            chk("result", result, e_res);
            chk("zero", zero, e_zero);
            chk("neg", neg, e_neg);
            chk("err_op", err_op, e_eop);
            chk("err_div0", err_div0, e_ediv);
        end
    end

    // Issue one op, scramble operands after accept, and measure done latency.
    task automatic run_op(input string nm, input logic [12:0] c, input logic [31:0] a,
                          input logic [31:0] b, input int exp_cyc, input logic [63:0] exp_r);
        int cyc;
        @(negedge clk);
        ctrl_signal = c; X = a; Y = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; X = $urandom; Y = $urandom; ctrl_signal = C_ADD;
        cyc = 1;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk({nm, "_lat"}, 64'(cyc), 64'(exp_cyc));
        chk({nm, "_res"}, result, exp_r);
    endtask

    initial begin
        int nd;
        @(posedge clk);
        #1 chk_on = 1'b1;
        @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_zero", zero, 1);
        chk("rst_errs", {err_op, err_div0, neg}, 0);
        clr = 1'b1;

        run_op("add", C_ADD, 32'd7, 32'hFFFF_FFFD, 1, 64'h4);
        run_op("sub", C_SUB, 32'd3, 32'd7, 1, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("sub_neg", neg, 1);
        run_op("incpc", C_INC, 32'h55, 32'h100, 1, 64'h104);
        run_op("rol", C_ROL, 32'h8000_0001, 32'd4, 1, 64'h18);
        run_op("and", C_AND, 32'hF0F0, 32'h0FF0, 1, 64'hF0);
        run_op("or", C_OR, 32'hF000, 32'h000F, 1, 64'hF00F);
        run_op("shr", C_SHR, 32'h8000_0000, 32'd4, 1, 64'h0800_0000);
        run_op("shl", C_SHL, 32'h0000_0003, 32'd31, 1, 64'hFFFF_FFFF_8000_0000);
        run_op("ror", C_ROR, 32'h1, 32'd1, 1, 64'hFFFF_FFFF_8000_0000);
        run_op("neg", C_NEG, 32'd5, 32'd5, 1, 64'hFFFF_FFFF_FFFF_FFFB);
        run_op("not", C_NOT, 32'hFFFF_0000, 32'hFFFF_0000, 1, 64'h0000_FFFF);
        run_op("mul1", C_MUL, 32'hFFFF_FFFD, 32'd7, 33, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("mul2", C_MUL, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 33, 64'h3FFF_FFFF_0000_0001);
        run_op("mul3", C_MUL, 32'h8000_0000, 32'h8000_0000, 33, 64'h4000_0000_0000_0000);
        run_op("div1", C_DIV, 32'hFFFF_FFF9, 32'd2, 34, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("div2", C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 34, 64'h0000_0000_8000_0000);
        run_op("div3", C_DIV, 32'd7, 32'hFFFF_FFFE, 34, 64'h0000_0001_FFFF_FFFD);
        run_op("div0", C_DIV, 32'd5, 32'd0, 1, 64'h0000_0005_0000_0000);
        chk("div0_flag", err_div0, 1);
        run_op("badop", 13'h0003, 32'd1, 32'd2, 1, 64'h0);
        chk("badop_flag", err_op, 1);
        run_op("clear", C_ADD, 32'd1, 32'd1, 1, 64'h2);
        chk("clear_flags", {err_op, err_div0}, 0);

        // start held high throughout a multiply: exactly one accept
        @(negedge clk);
        ctrl_signal = C_MUL; X = 32'hFFFF_FFFD; Y = 32'd7; start = 1'b1;
        nd = 0;
        repeat (BITS + 1) begin
            @(negedge clk);
            if (done) nd++;
            X = $urandom;
        end
        start = 1'b0;
        chk("hold_dones", 64'(nd), 1);
        chk("hold_res", result, 64'hFFFF_FFFF_FFFF_FFEB);

        // back-to-back adds: accepts every second edge
        @(negedge clk);
        ctrl_signal = C_ADD; X = 32'd10; Y = 32'd1; start = 1'b1;
        nd = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) nd++;
            X = X + 1;
        end
        start = 1'b0;
        chk("b2b_dones", 64'(nd), 4);
        chk("b2b_res", result, 64'd17);

        // reset in the middle of a multiply
        @(negedge clk);
        ctrl_signal = C_MUL; X = 32'hFFFF_FFFD; Y = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        chk("mid_rst_done", done, 0);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_zero", zero, 1);
        @(negedge clk);
        chk("mid_rst_ready", ready, 1);
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("mid_rst_nodone", 64'(nd), 0);

        run_op("post_rst", C_SUB, 32'd9, 32'd9, 1, 64'h0);
        chk("post_rst_zero", zero, 1);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
